dst_buf: RTL and testbench

Result buffer at the output side of the core: the exec datapath writes 32-bit result words at random addresses into one of two 256-word banks. A bank is handed off with a done strobe, then drained to the host/DMA side as eight 1024-bit beats over a valid/ready stream. It is the write-narrow/read-wide counterpart of the source buffer. Ping-pong banking lets exec fill one bank while the other drains.

---
 rtl/dst_buf.sv | 143 ++++++++++++++
 tb/tb_dst_buf.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dst_buf.sv
// Ping-pong result buffer: exec writes 32-bit words into one of two banks,
// and a completed bank drains as eight full-row beats over a valid/ready stream.
module dst_buf #(
  parameter int unsigned BANK_WORDS = 256,
  parameter int unsigned BEAT_WORDS = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      exec,
  input  logic [8:0]                exec_dst_addr,
  input  logic [31:0]               exec_dst_data,
  input  logic                      bank_done,
  input  logic                      bank_done_sel,
  output logic                      dst_v,
  input  logic                      dst_ready,
  output logic [8:0]                dst_a,
  output logic [32*BEAT_WORDS-1:0]  dst_d,
  output logic                      dst_last,
  output logic [1:0]                bank_busy,
  output logic                      err
);

  localparam logic [2:0] LAST_ROW = 3'(BANK_WORDS / BEAT_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state_q, state_d;
  logic                      bank_q, bank_d;
  logic [2:0]                row_q, row_d;
  logic                      last_bank_q, last_bank_d;
  logic [1:0]                busy_q, busy_d;
  logic                      err_q, err_d;
  logic [8:0]                dst_a_q, dst_a_d;
  logic                      dst_last_q, dst_last_d;
  logic [32*BEAT_WORDS-1:0]  dst_d_q, dst_d_d;

  logic                      load;
  logic                      rd_bank;
  logic [2:0]                rd_row;
  logic [32*BEAT_WORDS-1:0]  rd_data;

  // Row = {bank, addr[7:5]}, lane = addr[4:0]; contents are never reset.
  logic [31:0] mem_q [16][BEAT_WORDS];

  always_ff @(posedge clk) begin
    if (exec && !busy_q[exec_dst_addr[8]])
      mem_q[{exec_dst_addr[8], exec_dst_addr[7:5]}][exec_dst_addr[4:0]] <= exec_dst_data;
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < BEAT_WORDS; k++)
      rd_data[32*k +: 32] = mem_q[{rd_bank, rd_row}][k[4:0]];
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    row_d       = row_q;
    last_bank_d = last_bank_q;
    busy_d      = busy_q;
    err_d       = err_q;
    dst_a_d     = dst_a_q;
    dst_last_d  = dst_last_q;
    dst_d_d     = dst_d_q;
    load        = 1'b0;
    rd_bank     = bank_q;
    rd_row      = row_q;

    if (exec && busy_q[exec_dst_addr[8]])
      err_d = 1'b1;

    if (bank_done) begin
      if (busy_q[bank_done_sel]) err_d = 1'b1;
      else                       busy_d[bank_done_sel] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // With both banks pending, alternate away from the bank drained last.
        if (busy_q != 2'b00) begin
          rd_bank = (busy_q == 2'b11) ? ~last_bank_q : busy_q[1];
          rd_row  = '0;
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (dst_ready) begin
          if (row_q == LAST_ROW) begin
            busy_d[bank_q] = 1'b0;
            last_bank_d    = bank_q;
            state_d        = IDLE;
          end else begin
            rd_row = row_q + 3'd1;
            load   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      bank_d     = rd_bank;
      row_d      = rd_row;
      dst_a_d    = {rd_bank, rd_row, 5'd0};
      dst_last_d = (rd_row == LAST_ROW);
      dst_d_d    = rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bank_q      <= 1'b0;
      row_q       <= '0;
      last_bank_q <= 1'b1;
      busy_q      <= '0;
      err_q       <= 1'b0;
      dst_a_q     <= '0;
      dst_last_q  <= 1'b0;
      dst_d_q     <= '0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      last_bank_q <= last_bank_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      dst_a_q     <= dst_a_d;
      dst_last_q  <= dst_last_d;
      dst_d_q     <= dst_d_d;
    end
  end

  assign dst_v     = (state_q == SEND);
  assign dst_a     = dst_a_q;
  assign dst_d     = dst_d_q;
  assign dst_last  = dst_last_q;
  assign bank_busy = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dst_buf.sv
// Bench for dst_buf: directed scenarios with random data/ready, checked every
// cycle against a word-addressed reference memory and a bank-level drain model.
module tb_dst_buf;

  logic          clk = 1'b0;
  logic          rst;
  logic          exec;
  logic [8:0]    exec_dst_addr;
  logic [31:0]   exec_dst_data;
  logic          bank_done;
  logic          bank_done_sel;
  logic          dst_v;
  logic          dst_ready;
  logic [8:0]    dst_a;
  logic [1023:0] dst_d;
  logic          dst_last;
  logic [1:0]    bank_busy;
  logic          err;

  int checks   = 0;
  int failures = 0;

  dst_buf #(.BANK_WORDS(256), .BEAT_WORDS(32)) dut (
    .clk(clk), .rst(rst), .exec(exec), .exec_dst_addr(exec_dst_addr),
    .exec_dst_data(exec_dst_data), .bank_done(bank_done), .bank_done_sel(bank_done_sel),
    .dst_v(dst_v), .dst_ready(dst_ready), .dst_a(dst_a), .dst_d(dst_d),
    .dst_last(dst_last), .bank_busy(bank_busy), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0]  ref_mem [512];
  logic [1:0]   mbusy;
  logic         merr;
  logic         m_active;
  logic         m_bank;
  int unsigned  m_row;
  logic         m_last;
  int unsigned  cyc_n = 0;
  int unsigned  beats_log [$];
  int unsigned  hs_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      int w;
      w = 0;
      failures++;
      for (int k = 31; k >= 0; k--)
        if (obs[32*k +: 32] !== exp[32*k +: 32]) w = k;
      $error("FAIL %s word%0d observed=%h expected=%h", tag, w, obs[32*w +: 32], exp[32*w +: 32]);
    end
  endtask

  function automatic logic [1023:0] ref_row(input logic b, input int unsigned r);
    logic [1023:0] v;
    logic [8:0]    base;
    base = {b, 3'(r), 5'd0};
    for (int k = 0; k < 32; k++) v[32*k +: 32] = ref_mem[base + 9'(k)];
    return v;
  endfunction

  task automatic model_reset();
    mbusy    = 2'b00;
    merr     = 1'b0;
    m_active = 1'b0;
    m_bank   = 1'b0;
    m_row    = 0;
    m_last   = 1'b1;
  endtask

  // One clock cycle: check this cycle's outputs, drive inputs, advance the model.
  task automatic cyc(input logic e, input logic [8:0] a, input logic [31:0] d,
                     input logic dn, input logic ds, input logic rdy);
    logic [1:0] nb;
    logic       ne;
    @(negedge clk);
    cyc_n++;
    chk("dst_v", 32'(dst_v), 32'(m_active));
    chk("bank_busy", 32'(bank_busy), 32'(mbusy));
    chk("err", 32'(err), 32'(merr));
    if (m_active) begin
      chk("dst_a", 32'(dst_a), 32'(m_bank) * 256 + m_row * 32);
      chk("dst_last", 32'(dst_last), 32'(m_row == 7));
      chk_beat("dst_d", dst_d, ref_row(m_bank, m_row));
    end
    exec = e; exec_dst_addr = a; exec_dst_data = d;
    bank_done = dn; bank_done_sel = ds; dst_ready = rdy;

    nb = mbusy;
    ne = merr;
    if (e) begin
      if (mbusy[a[8]]) ne = 1'b1;
      else             ref_mem[a] = d;
    end
    if (dn) begin
      if (mbusy[ds]) ne = 1'b1;
      else           nb[ds] = 1'b1;
    end
    if (m_active) begin
      if (rdy) begin
        beats_log.push_back(32'(m_bank) * 256 + m_row * 32);
        hs_cyc.push_back(cyc_n);
        if (m_row == 7) begin
          nb[m_bank] = 1'b0;
          m_last     = m_bank;
          m_active   = 1'b0;
        end else begin
          m_row++;
        end
      end
    end else if (mbusy != 2'b00) begin
      m_bank   = (mbusy == 2'b11) ? ~m_last : mbusy[1];
      m_row    = 0;
      m_active = 1'b1;
    end
    mbusy = nb;
    merr  = ne;
  endtask

  function automatic logic pick_rdy(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (i % 2 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic fill(input logic b, input logic counting, input int rmode);
    for (int i = 0; i < 256; i++)
      cyc(1'b1, {b, 8'(i)}, counting ? 32'h1000 + 32'(i) : $urandom, 1'b0, 1'b0, pick_rdy(rmode, i));
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0, pick_rdy(rmode, i));
  endtask

  task automatic done(input logic b, input logic rdy);
    cyc(1'b0, '0, '0, 1'b1, b, rdy);
  endtask

  initial begin
    rst = 1'b1; exec = 1'b0; exec_dst_addr = '0; exec_dst_data = '0;
    bank_done = 1'b0; bank_done_sel = 1'b0; dst_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_dst_v", 32'(dst_v), 32'd0);
    chk("rst_dst_a", 32'(dst_a), 32'd0);
    chk_beat("rst_dst_d", dst_d, '0);
    chk("rst_dst_last", 32'(dst_last), 32'd0);
    chk("rst_bank_busy", 32'(bank_busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Single bank drain with counting data and ready held high.
    fill(1'b0, 1'b1, 0);
    beats_log.delete(); hs_cyc.delete();
    done(1'b0, 1'b1);
    idle(12, 0);
    chk("single_beats", 32'(beats_log.size()), 32'd8);
    if (beats_log.size() == 8) begin
      chk("single_first_a", beats_log[0], 32'd0);
      chk("single_last_a", beats_log[7], 32'd224);
      chk("single_back_to_back", hs_cyc[7] - hs_cyc[0], 32'd7);
    end

    // Ping-pong: fill bank 1 while bank 0 drains with toggling ready.
    fill(1'b0, 1'b0, 0);
    beats_log.delete(); hs_cyc.delete();
    done(1'b0, 1'b1);
    fill(1'b1, 1'b0, 1);
    done(1'b1, 1'b1);
    idle(20, 0);
    chk("pp_beats", 32'(beats_log.size()), 32'd16);
    if (beats_log.size() == 16) begin
      chk("pp_bank0_first", beats_log[0], 32'd0);
      chk("pp_bank1_follows", beats_log[8], 32'd256);
    end

    // Both pending: bank 1 pends alone first, then bank 0 follows.
    beats_log.delete(); hs_cyc.delete();
    done(1'b1, 1'b1);
    done(1'b0, 1'b1);
    idle(25, 0);
    chk("both_beats", 32'(beats_log.size()), 32'd16);
    if (beats_log.size() == 16) begin
      chk("both_bank1_first", beats_log[0], 32'd256);
      chk("both_bank0_second", beats_log[8], 32'd0);
      chk("both_gap", hs_cyc[8] - hs_cyc[7], 32'd2);
    end

    // Backpressure on beat 3 while exec writes randomly into the free bank.
    done(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (m_active && m_row == 3) break;
      cyc(1'b1, {1'b1, 8'($urandom_range(0, 255))}, $urandom, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, {1'b1, 8'($urandom_range(0, 255))}, $urandom, 1'b0, 1'b0, 1'b0);
      chk("bp_hold_v", 32'(dst_v), 32'd1);
      chk("bp_hold_a", 32'(dst_a), 32'd96);
    end
    for (int i = 0; i < 12; i++)
      cyc(1'b1, {1'b1, 8'($urandom_range(0, 255))}, $urandom, 1'b0, 1'b0, 1'b1);
    idle(4, 0);

    // Violations: write into busy bank 0, then a repeated bank_done.
    beats_log.delete(); hs_cyc.delete();
    done(1'b0, 1'b0);
    cyc(1'b1, 9'd5, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("viol_err", 32'(err), 32'd1);
    idle(30, 2);
    idle(10, 0);
    chk("viol_beats", 32'(beats_log.size()), 32'd8);

    // Reset mid-drain, with ready low on beat 4.
    done(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (m_active && m_row == 4) break;
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    end
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_dst_v", 32'(dst_v), 32'd0);
    chk("arst_bank_busy", 32'(bank_busy), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    fill(1'b0, 1'b0, 0);
    beats_log.delete(); hs_cyc.delete();
    done(1'b0, 1'b1);
    idle(12, 0);
    chk("post_rst_beats", 32'(beats_log.size()), 32'd8);
    if (beats_log.size() > 0) chk("post_rst_first_a", beats_log[0], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
